// File: rtl/seq_mant_divider.sv
// seq_mant_divider: radix-2 restoring mantissa divider, one quotient bit per clock; `define DIV_STICKY_EN adds a sticky output
module seq_mant_divider #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
`ifdef DIV_STICKY_EN
  output logic             sticky,
`endif
  output logic             div_by_zero
);
  localparam int S = WIDTH / 4 + 1;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] d, v, r, q, diff, r_nxt, q_nxt;
  logic [CW-1:0] n;
  logic [WIDTH+3:0] a_ext, b_ext;
  logic [4:0] c;
  logic cy, ge;
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] p, g;
    p = x ^ y;
    g = x & y;
    return {g[3] | p[3]&g[2] | p[3]&p[2]&g[1] | p[3]&p[2]&p[1]&g[0] | &p & ci,
            g[2] | p[2]&g[1] | p[2]&p[1]&g[0] | &p[2:0] & ci,
            g[1] | p[1]&g[0] | &p[1:0] & ci,
            g[0] | p[0]&ci,
            ci};
  endfunction
  assign a_ext = {3'b000, r, d[WIDTH-1]};
  assign b_ext = ~{4'b0000, v};
  // the top slice only yields the borrow; its sum bits are never needed
  always_comb begin
    diff = '0;
    cy = 1'b1;
    c = '0;
    for (int s = 0; s < S - 1; s++) begin
      c = cla4(a_ext[4*s+:4], b_ext[4*s+:4], cy);
      diff[4*s+:4] = a_ext[4*s+:4] ^ b_ext[4*s+:4] ^ c[3:0];
      cy = c[4];
    end
    c = cla4(a_ext[WIDTH+:4], b_ext[WIDTH+:4], cy);
    ge = c[4];
  end
  assign r_nxt = ge ? diff : a_ext[WIDTH-1:0];
  assign q_nxt = {q[WIDTH-2:0], ge};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      d <= '0;
      v <= '0;
      r <= '0;
      q <= '0;
      n <= '0;
      quotient <= '0;
      remainder <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef DIV_STICKY_EN
      sticky <= 1'b0;
`endif
    end else if (state != RUN && start) begin
      d <= dividend;
      v <= divisor;
      r <= '0;
      q <= '0;
      n <= '0;
      if (divisor == '0) begin
        state <= DONE;
        done <= 1'b1;
        quotient <= '1;
        remainder <= dividend;
        div_by_zero <= 1'b1;
`ifdef DIV_STICKY_EN
        sticky <= 1'b1;
`endif
      end else begin
        state <= RUN;
        busy <= 1'b1;
        done <= 1'b0;
      end
    end else if (state == RUN) begin
      r <= r_nxt;
      q <= q_nxt;
      d <= {d[WIDTH-2:0], 1'b0};
      n <= n + 1'b1;
      if (n == CW'(WIDTH - 1)) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        quotient <= q_nxt;
        remainder <= r_nxt;
        div_by_zero <= 1'b0;
`ifdef DIV_STICKY_EN
        sticky <= |r_nxt;
`endif
      end
    end else begin
      state <= IDLE;
      done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_mant_divider.sv
// tb_seq_mant_divider: directed and random checks of seq_mant_divider at WIDTH=8 and WIDTH=24 against arithmetic / and %
module tb_seq_mant_divider;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic s8, s24, bs8, dn8, z8, bs24, dn24, z24;
  logic [7:0] a8, b8, q8, r8;
  logic [23:0] a24, b24, q24, r24;
`ifdef DIV_STICKY_EN
  logic st8, st24;
`endif
  int tests = 0;
  int fails = 0;
  logic [23:0] lq8 = '0;
  logic [23:0] lq24 = '0;

  seq_mant_divider #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .dividend(a8), .divisor(b8),
    .quotient(q8), .remainder(r8), .busy(bs8), .done(dn8),
`ifdef DIV_STICKY_EN
    .sticky(st8),
`endif
    .div_by_zero(z8));

  seq_mant_divider #(.WIDTH(24)) u24 (
    .clk(clk), .rst(rst), .start(s24), .dividend(a24), .divisor(b24),
    .quotient(q24), .remainder(r24), .busy(bs24), .done(dn24),
`ifdef DIV_STICKY_EN
    .sticky(st24),
`endif
    .div_by_zero(z24));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] gq(input int w);
    return w == 8 ? {16'b0, q8} : q24;
  endfunction
  function automatic logic [23:0] gr(input int w);
    return w == 8 ? {16'b0, r8} : r24;
  endfunction
  function automatic logic gd(input int w);
    return w == 8 ? dn8 : dn24;
  endfunction
  function automatic logic gb(input int w);
    return w == 8 ? bs8 : bs24;
  endfunction
  function automatic logic gz(input int w);
    return w == 8 ? z8 : z24;
  endfunction
`ifdef DIV_STICKY_EN
  function automatic logic gs(input int w);
    return w == 8 ? st8 : st24;
  endfunction
`endif

  task automatic op(input int w, input logic [23:0] x, input logic [23:0] y);
    logic [23:0] m, eq, er;
    int lat;
    m = (w == 8) ? 24'hFF : 24'hFFFFFF;
    x = x & m;
    y = y & m;
    eq = (y == 0) ? m : x / y;
    er = (y == 0) ? x : x % y;
    if (w == 8) begin
      a8 = x[7:0];
      b8 = y[7:0];
      s8 = 1'b1;
    end else begin
      a24 = x;
      b24 = y;
      s24 = 1'b1;
    end
    @(posedge clk);
    #1;
    s8 = 1'b0;
    s24 = 1'b0;
    chk("busy_after_start", gb(w), y != 0);
    if (y != 0) chk("hold_during_run", gq(w), (w == 8) ? lq8 : lq24);
    lat = 0;
    while (!gd(w) && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, (y == 0) ? 0 : w);
    chk("quotient", gq(w), eq);
    chk("remainder", gr(w), er);
    chk("div_by_zero", gz(w), y == 0);
`ifdef DIV_STICKY_EN
    chk("sticky", gs(w), (y == 0) || (er != 0));
`endif
    if (w == 8) lq8 = eq;
    else lq24 = eq;
    @(posedge clk);
    #1;
    chk("done_one_cycle", gd(w), 0);
    chk("hold_after_done", gq(w), eq);
  endtask

  initial begin
    logic [7:0] ha[64];
    logic [7:0] hb[64];
    int last_done, ndone, seen;
    rst = 1'b1;
    s8 = 1'b0;
    s24 = 1'b0;
    a8 = '0;
    b8 = '0;
    a24 = '0;
    b24 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quotient", q8, 0);
    chk("rst_remainder", r8, 0);
    chk("rst_busy", bs8, 0);
    chk("rst_done", dn8, 0);
    chk("rst_dbz", z8, 0);
    chk("rst_quotient24", q24, 0);
    rst = 1'b0;
    op(8, 100, 7);
    op(8, 255, 1);
    op(8, 15, 16);
    op(8, 24'h5A, 0);
    a8 = 100;
    b8 = 7;
    s8 = 1'b1;
    @(posedge clk);
    #1;
    s8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_mid_run", bs8, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", bs8, 0);
    chk("async_rst_quotient", q8, 0);
    chk("async_rst_remainder", r8, 0);
    chk("async_rst_dbz", z8, 0);
    chk("async_rst_done", dn8, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lq8 = '0;
    lq24 = '0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen = seen | int'(dn8);
    end
    chk("no_done_after_rst", seen, 0);
    op(8, 100, 7);
    op(8, 0, 9);
    last_done = -1;
    ndone = 0;
    s8 = 1'b1;
    for (int c = 0; c < 45; c++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom_range(1, 255));
      ha[c] = a8;
      hb[c] = b8;
      @(posedge clk);
      #1;
      if (dn8) begin
        ndone++;
        chk("b2b_first_done", int'(c >= 8), 1);
        if (c >= 8) begin
          chk("b2b_quotient", q8, ha[c-8] / hb[c-8]);
          chk("b2b_remainder", r8, ha[c-8] % hb[c-8]);
          lq8 = {16'b0, ha[c-8] / hb[c-8]};
        end
        if (last_done >= 0) chk("b2b_gap", c - last_done, 9);
        last_done = c;
      end
    end
    s8 = 1'b0;
    chk("b2b_count", ndone, 5);
    repeat (2) @(posedge clk);
    #1;
    op(24, 24'hFFFFFF, 24'h800000);
    op(24, 24'h800000, 24'hFFFFFF);
    op(24, 24'hFFFFFF, 24'h000001);
    op(24, 24'h800000, 24'h800000);
    op(24, 24'hFFFFFF, 24'h000000);
    op(24, 24'h000000, 24'h800000);
    for (int i = 0; i < 1000; i++)
      op(24, 24'($urandom), ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom_range(0, 4095)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_mant_divider.md
Name: seq_mant_divider

Overview:
- Sequential radix-2 restoring divider for floating-point mantissas.
- It is the divide-path counterpart of the mantissa multiplier: one quotient bit per clock.
- Each trial subtraction uses ripple-chained 4-bit CLA slices, adding the inverted divisor with carry-in 1.
- Feeds the FP divide normaliser and rounder. Start/done handshake towards the exponent/control logic.

Parameters:
- WIDTH, 24, operand/quotient/remainder width in bits (mantissa including hidden bit); must be a multiple of 4, minimum 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only when busy=0
- dividend  input  WIDTH  unsigned dividend, captured on accepted start
- divisor  input  WIDTH  unsigned divisor, captured on accepted start
- quotient  output  WIDTH  floor(dividend/divisor)
- remainder  output  WIDTH  dividend mod divisor
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; results valid
- div_by_zero  output  1  divisor was 0 for the completed operation

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all outputs 0; internal registers 0.
  - rst asserted mid-operation aborts immediately; no done pulse follows.
- States: IDLE, RUN, DONE.
- Accepted start: start=1 at a rising edge while state is IDLE or DONE (busy=0).
  - start while busy=1 is ignored; operands are not re-captured.
- On accepted start at edge k, divisor!=0:
  - Capture dividend into shift register D and divisor into V; clear R (WIDTH+1 bits) and Q; iteration count n=0.
  - state=RUN, busy=1.
- RUN, each edge:
  - T = {R[WIDTH-1:0], D[MSB]} - {1'b0, V}, computed as an add of ~V with carry-in 1 across WIDTH/4+1 slices.
  - If no borrow (carry-out 1): R=T, quotient bit 1; else R unchanged but shifted, bit 0.
  - Shift D left; shift the bit into Q LSB; n=n+1.
- After WIDTH iterations (edge k+WIDTH):
  - quotient=Q, remainder=R[WIDTH-1:0], div_by_zero=0.
  - state=DONE, busy=0, done=1.
  - Latency start→done = WIDTH cycles.
- DONE:
  - done is high for exactly one cycle, then state=IDLE, done=0.
  - A start in DONE is accepted (back-to-back).
- Result hold: quotient/remainder/div_by_zero hold their values until the next completion. They do not change on start or during RUN.
- Divide by zero (divisor=0 at accepted start):
  - No RUN phase; next edge state=DONE, done=1.
  - quotient=all ones, remainder=dividend, div_by_zero=1.
- dividend=0: normal RUN; quotient=0, remainder=0.
- divisor>dividend: quotient=0, remainder=dividend.
- Arithmetic is unsigned; no overflow is possible (quotient ≤ dividend).

Optional Feature:
- Macro: DIV_STICKY_EN.
- Defined:
  - Adds output port sticky (1 bit); reset value 0.
  - Updated together with quotient at completion: sticky = (remainder != 0).
  - Divide by zero: sticky=1.
  - Consumed by the rounder.
- Undefined:
  - Port absent; no remainder-OR logic.
  - All other behaviour identical.

Test Plan:
- WIDTH=8, dividend=100, divisor=7, start one cycle:
  - busy=1 for 8 cycles; done pulses 8 cycles after start edge.
  - quotient=14, remainder=2, div_by_zero=0; sticky=1 if enabled.
- WIDTH=8, 255/1 → quotient=255, remainder=0, sticky=0. Then 15/16 → quotient=0, remainder=15.
- divisor=0, dividend=0x5A:
  - done on the next cycle; quotient=0xFF, remainder=0x5A, div_by_zero=1.
- start held high continuously with new operands each cycle:
  - Only operands present at the IDLE/DONE edges are used.
  - Back-to-back results arrive every WIDTH+1 cycles; mid-RUN operand changes have no effect.
- rst pulsed at iteration 4 of 100/7:
  - All outputs 0 immediately (asynchronously); no done pulse.
  - A new start then produces correct results.
- WIDTH=24, random 1000 pairs including 0xFFFFFF and 0x800000:
  - quotient/remainder match a reference model; done latency always 24.
